// File: rtl/add_round_key_seq.sv
// add_round_key_seq: sequential AES AddRoundKey with a loadable round-key table,
// XORing one LANE_W slice per cycle behind valid/ready handshakes.
module add_round_key_seq #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 32,
  parameter int NUM_KEYS = 11,
  localparam int KIDX_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [KIDX_W-1:0] key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KIDX_W-1:0] in_kidx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] keys [NUM_KEYS];
  logic [DATA_W-1:0] work, key_w, work_x;
  logic err_w, last, kidx_ok, accept;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign last = cnt == CNT_W'(BEATS - 1);
  assign kidx_ok = 32'(in_kidx) < NUM_KEYS;
  assign accept = in_valid && in_ready;
  always_comb begin
    work_x = work;
    work_x[int'(cnt)*LANE_W +: LANE_W] = work[int'(cnt)*LANE_W +: LANE_W] ^ key_w[int'(cnt)*LANE_W +: LANE_W];
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && accept) ? RUN :
               (state == RUN && last) ? HOLD :
               (state == HOLD && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // The key is snapshotted at accept, so later table writes never reach an in-flight block.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      work <= '0;
      key_w <= '0;
      err_w <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
    end else begin
      if (key_we && 32'(key_waddr) < NUM_KEYS) keys[key_waddr] <= key_wdata;
      if (state == IDLE && accept) begin
        work <= in_data;
        key_w <= kidx_ok ? keys[in_kidx] : '0;
        err_w <= !kidx_ok;
        cnt <= '0;
      end else if (state == RUN) begin
        work <= work_x;
        cnt <= cnt + 1'b1;
        if (last) begin
          out_data <= work_x;
          out_err <= err_w;
        end
      end
    end
endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq: vector table, corner sequences and randomized blocks
// checked against a table-level XOR model.
module tb_add_round_key_seq;
  logic clk = 0, rst = 1, key_we = 0, in_valid = 0, out_ready = 0;
  logic [3:0] key_waddr = 0, in_kidx = 0;
  logic [127:0] key_wdata = 0, in_data = 0;
  logic in_ready, out_valid, out_err, busy;
  logic [127:0] out_data;
  logic ir_w, ov_w, oe_w, bz_w, ir_n, ov_n, oe_n, bz_n;
  logic [127:0] od_w, od_n;
  int checks = 0, errors = 0;
  localparam logic [127:0] K1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] D0 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] R0 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] DB = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] mkeys [11];
  typedef struct {logic [127:0] d; logic [3:0] k; logic [127:0] e; logic err;} vec_t;
  vec_t vt [4];

  add_round_key_seq dut (.clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr),
    .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kidx(in_kidx), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy));
  add_round_key_seq #(.LANE_W(128)) dut_w (.clk(clk), .rst(rst), .key_we(key_we),
    .key_waddr(key_waddr), .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(ir_w),
    .in_data(in_data), .in_kidx(in_kidx), .out_valid(ov_w), .out_ready(out_ready),
    .out_data(od_w), .out_err(oe_w), .busy(bz_w));
  add_round_key_seq #(.LANE_W(8)) dut_n (.clk(clk), .rst(rst), .key_we(key_we),
    .key_waddr(key_waddr), .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(ir_n),
    .in_data(in_data), .in_kidx(in_kidx), .out_valid(ov_n), .out_ready(out_ready),
    .out_data(od_n), .out_err(oe_n), .busy(bz_n));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [3:0] k);
    return k < 11 ? d ^ mkeys[k] : d;
  endfunction

  task automatic write_key(input logic [3:0] a, input logic [127:0] v);
    key_we = 1; key_waddr = a; key_wdata = v;
    @(posedge clk); #1 key_we = 0;
    if (a < 11) mkeys[a] = v;
  endtask

  task automatic accept(input logic [127:0] d, input logic [3:0] k);
    bit ok = 0;
    in_data = d; in_kidx = k; in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("accept_ready", ok, 1);
    @(posedge clk); #1 in_valid = 0; key_we = 0;
  endtask

  task automatic wait_out(output int lat);
    for (lat = 0; lat < 40; lat++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
  endtask

  initial begin
    int lat, l0, l1, l2, r;
    logic seen;
    logic [127:0] d, e;
    logic [3:0] k;
    for (int i = 0; i < 11; i++) mkeys[i] = '0;
    vt[0] = '{D0, 4'd1, R0, 1'b0};
    vt[1] = '{DB, 4'd12, DB, 1'b1};
    vt[2] = '{DB, 4'd15, DB, 1'b1};
    vt[3] = '{D0, 4'd0, D0, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;
    write_key(1, K1);
    in_data = D0; in_kidx = 1; in_valid = 1; out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    l0 = -1; l1 = -1; l2 = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid && l0 < 0) begin l0 = c; chk("sweep32_data", out_data, R0); end
      if (ov_w && l1 < 0) begin l1 = c; chk("sweep128_data", od_w, R0); end
      if (ov_n && l2 < 0) begin l2 = c; chk("sweep8_data", od_n, R0); end
      @(posedge clk);
    end
    #1;
    chk("sweep32_latency", l0, 4);
    chk("sweep128_latency", l1, 1);
    chk("sweep8_latency", l2, 16);
    foreach (vt[i]) begin
      accept(vt[i].d, vt[i].k);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].e);
      chk($sformatf("vec%0d_err", i), out_err, vt[i].err);
      @(posedge clk); #1;
    end
    out_ready = 0;
    accept(D0, 1);
    wait_out(lat);
    for (int i = 0; i < 6; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, R0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);
    chk("bp_hs_busy", busy, 0);
    chk("bp_hs_data_held", out_data, R0);
    @(posedge clk); #1;
    accept(D0, 1);
    write_key(1, '1);
    wait_out(lat);
    chk("hazard_inflight_data", out_data, R0);
    @(posedge clk); #1;
    accept(D0, 1);
    wait_out(lat);
    chk("hazard_newkey_data", out_data, model(D0, 1));
    @(posedge clk); #1;
    e = model(D0, 1);
    key_we = 1; key_waddr = 1; key_wdata = K1;
    accept(D0, 1);
    mkeys[1] = K1;
    wait_out(lat);
    chk("same_edge_write_data", out_data, e);
    @(posedge clk); #1;
    accept(D0, 1);
    wait_out(lat);
    chk("after_same_edge_data", out_data, model(D0, 1));
    @(posedge clk); #1;
    accept(D0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_in_ready", in_ready, 0);
    chk("midrun_rst_out_data", out_data, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 11; i++) mkeys[i] = '0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("midrun_no_out_valid", seen, 0);
    @(posedge clk); #1;
    accept(D0, 1);
    wait_out(lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_data", out_data, model(D0, 1));
    chk("post_rst_err", out_err, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) write_key(4'(i), {$urandom, $urandom, $urandom, $urandom});
    write_key(13, {$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = 4'($urandom_range(0, 15));
      out_ready = 0;
      accept(d, k);
      wait_out(lat);
      chk("rand_latency", lat, 4);
      chk("rand_data", out_data, model(d, k));
      chk("rand_err", out_err, k >= 11);
      r = $urandom_range(0, 3);
      repeat (r) begin
        @(negedge clk);
        chk("rand_hold_data", out_data, model(d, k));
      end
      out_ready = 1;
      @(posedge clk); #1 out_ready = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
